// File: rtl/vec_load_gather.sv
// Vector load gather: fetches vectorSize elements at baseAddr + lane*stride and writes them as one vector.
// Optional macro VEC_LOAD_MASK_EN adds the laneMask port for per-lane skipping.
module vec_load_gather #(
   parameter int registerSize  = 8,
   parameter int selectionBits = 2,
   parameter int vectorSize    = 4,
   parameter int addrWidth     = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [addrWidth-1:0]                   baseAddr,
   input  logic [addrWidth-1:0]                   stride,
   input  logic [selectionBits-1:0]               destReg,
   output logic                                   memRdEn,
   output logic [addrWidth-1:0]                   memAddr,
   input  logic [registerSize-1:0]                memRdData,
   input  logic                                   memRdValid,
   output logic                                   regWrEn,
   output logic [selectionBits-1:0]               regToWrite,
   output logic [vectorSize*registerSize-1:0]     regWriteData,
   output logic                                   busy,
   output logic                                   done
`ifdef VEC_LOAD_MASK_EN
   ,
   input  logic [vectorSize-1:0]                  laneMask
`endif
);

   localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

   state_t                                     state, state_next;
   logic [LW-1:0]                              lane, lane_next;
   logic [addrWidth-1:0]                       base, step;
   logic [selectionBits-1:0]                   dest;
   logic [vectorSize-1:0][registerSize-1:0]    buffer, buffer_next, vec_q;
   logic                                       first_found, after_found;
   logic [LW-1:0]                              first_lane, after_lane;

`ifdef VEC_LOAD_MASK_EN
   logic [vectorSize-1:0]                      mask;

   // Descending scans so the lowest qualifying lane wins.
   always_comb begin
      first_found = 1'b0;
      first_lane  = '0;
      after_found = 1'b0;
      after_lane  = '0;
      for (int unsigned i = vectorSize; i > 0; i--) begin
         if (laneMask[i-1]) begin
            first_found = 1'b1;
            first_lane  = LW'(i - 1);
         end
         if (mask[i-1] && ((i - 1) > 32'(lane))) begin
            after_found = 1'b1;
            after_lane  = LW'(i - 1);
         end
      end
   end
`else
   always_comb begin
      first_found = 1'b1;
      first_lane  = '0;
      after_found = (lane != LW'(vectorSize - 1));
      after_lane  = lane + 1'b1;
   end
`endif

   always_comb begin
      state_next  = state;
      lane_next   = lane;
      buffer_next = buffer;
      case (state)
         IDLE: begin
            if (start) begin
               lane_next   = first_lane;
               buffer_next = '0;
               state_next  = first_found ? REQ : WRITE;
            end
         end
         REQ:  state_next = WAIT;
         WAIT: begin
            if (memRdValid) begin
               buffer_next[lane] = memRdData;
               if (after_found) begin
                  lane_next  = after_lane;
                  state_next = REQ;
               end else begin
                  state_next = WRITE;
               end
            end
         end
         WRITE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lane   <= '0;
         buffer <= '0;
         vec_q  <= '0;
         base   <= '0;
         step   <= '0;
         dest   <= '0;
`ifdef VEC_LOAD_MASK_EN
         mask   <= '0;
`endif
      end else begin
         state  <= state_next;
         lane   <= lane_next;
         buffer <= buffer_next;
         // Output vector is loaded on entry to WRITE so it is valid alongside regWrEn.
         if (state_next == WRITE && state != WRITE)
            vec_q <= buffer_next;
         if (state == IDLE && start) begin
            base <= baseAddr;
            step <= stride;
            dest <= destReg;
`ifdef VEC_LOAD_MASK_EN
            mask <= laneMask;
`endif
         end
      end
   end

   always_comb begin
      memRdEn      = (state == REQ);
      memAddr      = (state == REQ) ? (base + addrWidth'(lane) * step) : '0;
      regWrEn      = (state == WRITE);
      done         = (state == WRITE);
      regToWrite   = (state == WRITE) ? dest : '0;
      busy         = (state != IDLE);
      regWriteData = vec_q;
   end

endmodule

// File: tb/tb_vec_load_gather.sv
// Self-checking bench for vec_load_gather: directed and random loads against a lane-list reference model.
module tb_vec_load_gather;

   logic        clk = 1'b0;
   logic        reset, start, memRdValid;
   logic [15:0] baseAddr, stride;
   logic [1:0]  destReg;
   logic [7:0]  memRdData;
   logic        memRdEn, regWrEn, busy, done;
   logic [15:0] memAddr;
   logic [1:0]  regToWrite;
   logic [31:0] regWriteData;
   logic [3:0]  laneMask;

   int total = 0;
   int bad   = 0;

   int         lat [4];
   logic [7:0] dat [4];
   logic [3:0] msk;
   bit         spur;

   vec_load_gather #(
      .registerSize(8), .selectionBits(2), .vectorSize(4), .addrWidth(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .stride(stride),
      .destReg(destReg), .memRdEn(memRdEn), .memAddr(memAddr), .memRdData(memRdData),
      .memRdValid(memRdValid), .regWrEn(regWrEn), .regToWrite(regToWrite),
      .regWriteData(regWriteData), .busy(busy), .done(done)
`ifdef VEC_LOAD_MASK_EN
      , .laneMask(laneMask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rden"}, memRdEn, 0);
      chk({tag, "_addr"}, memAddr, 0);
      chk({tag, "_wren"}, regWrEn, 0);
      chk({tag, "_dest"}, regToWrite, 0);
      chk({tag, "_data"}, regWriteData, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // One load: drives start, plays memory with per-lane latency, checks every request and the final write.
   task automatic run_load(input logic [15:0] b, input logic [15:0] s, input logic [1:0] d,
                           input int busy_start_at, input int reset_at);
      int          en[$];
      logic [15:0] exp_addr[$];
      logic [31:0] exp_vec;
      int          exp_cycle, nreq, valid_at, cur_lane;
      bit          completed;
      exp_vec   = '0;
      exp_cycle = 1;
      for (int j = 0; j < 4; j++) begin
         if (msk[j]) begin
            en.push_back(j);
            exp_addr.push_back(16'(b + 16'(j) * s));
            exp_vec[j*8 +: 8] = dat[j];
            exp_cycle += 1 + lat[j];
         end
      end
      nreq = 0; valid_at = -1; cur_lane = 0; completed = 0;

      @(negedge clk);
      chk("pre_start_busy", busy, 0);
      baseAddr = b; stride = s; destReg = d; laneMask = msk; start = 1'b1;
      memRdValid = spur; memRdData = 8'hEE;

      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         start = 1'b0; memRdValid = 1'b0; memRdData = 8'($urandom);
         reset = (c == reset_at);
         if (c == busy_start_at) begin
            start = 1'b1; baseAddr = ~b; destReg = ~d; laneMask = ~msk;
         end
         chk("done_eq_wren", done, regWrEn);
         if (memRdEn) begin
            if (nreq < en.size()) begin
               chk("req_addr", memAddr, exp_addr[nreq]);
               cur_lane = en[nreq];
               valid_at = c + lat[cur_lane];
            end else begin
               chk("extra_req", 1, 0);
            end
            nreq++;
            if (spur) begin
               memRdValid = 1'b1; memRdData = 8'hEE;
            end
         end
         if (c == valid_at) begin
            memRdValid = 1'b1; memRdData = dat[cur_lane];
         end
         if (reset_at != 0) begin
            if (c == reset_at + 1) chk_idle_outputs("after_reset");
            if (c > reset_at) chk("aborted_no_write", regWrEn, 0);
            if (c == reset_at + 6) begin
               completed = 1;
               break;
            end
         end else if (regWrEn) begin
            chk("write_cycle", c, exp_cycle);
            chk("write_data", regWriteData, exp_vec);
            chk("write_dest", regToWrite, d);
            chk("write_busy", busy, 1);
            chk("req_count", nreq, en.size());
            completed = 1;
            break;
         end
      end
      reset = 1'b0;
      if (!completed) chk("timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; memRdValid = 1'b0; memRdData = '0;
      baseAddr = '0; stride = '0; destReg = '0; laneMask = '1;
      msk = 4'hF; spur = 0;
      for (int j = 0; j < 4; j++) begin
         lat[j] = 1; dat[j] = 8'(8'hA0 + j);
      end
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset_state");
      reset = 1'b0;

      // Basic load: addresses 0x10..0x13, data {A3,A2,A1,A0} in cycle 9.
      run_load(16'h0010, 16'h0001, 2'd2, 0, 0);
      @(negedge clk);
      chk("hold_after_write", regWriteData, 32'hA3A2A1A0);
      chk("busy_falls", busy, 0);

      // Address wrap with stride 3 from 0xFFFE.
      for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
      run_load(16'hFFFE, 16'h0003, 2'd1, 0, 0);

      // Longer latency on lane 1 plus spurious valids in IDLE/REQ: write in cycle 11.
      lat[1] = 3; spur = 1;
      for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
      run_load(16'h0200, 16'h0004, 2'd3, 0, 0);
      spur = 0; lat[1] = 1;

      // Start while busy is ignored; reset during WAIT of lane 2 aborts the load.
      lat[2] = 3;
      run_load(16'h0300, 16'h0002, 2'd0, 3, 6);
      lat[2] = 1;
      for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
      run_load(16'h0400, 16'h0010, 2'd2, 0, 0);

`ifdef VEC_LOAD_MASK_EN
      msk = 4'b0101;
      for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
      run_load(16'h0500, 16'h0001, 2'd1, 0, 0);
      msk = 4'b0000;
      run_load(16'h0600, 16'h0001, 2'd3, 0, 0);
      msk = 4'hF;
`endif

      // Random back-to-back loads.
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) begin
            dat[j] = 8'($urandom);
            lat[j] = int'($urandom_range(1, 4));
         end
`ifdef VEC_LOAD_MASK_EN
         msk = 4'($urandom);
`endif
         spur = bit'($urandom_range(0, 1));
         run_load(16'($urandom), 16'($urandom), 2'($urandom), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vec_load_gather.md
# vec_load_gather

Vector load gather unit: on a start command it fetches `vectorSize` scalar elements of `registerSize` bits from byte-addressed data memory at `baseAddr + lane*stride`, one outstanding request at a time, and packs them lane by lane. It then issues a single one-cycle write of the assembled vector to the vector register file. It sits between data memory and the register file's write port and drives `regWrEn` / `regToWrite` / `regWriteData` for vector loads.

## Interface
- `registerSize`, 8, bits per lane element and per memory data word
- `selectionBits`, 2, width of the destination register index
- `vectorSize`, 4, lanes per vector (≥1)
- `addrWidth`, 16, memory address width
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  load command, sampled only in IDLE
- `baseAddr`  in  addrWidth  address of lane 0
- `stride`  in  addrWidth  address increment per lane (unsigned)
- `destReg`  in  selectionBits  target vector register
- `memRdEn`  out  1  one-cycle read request pulse
- `memAddr`  out  addrWidth  request address, valid while `memRdEn`=1
- `memRdData`  in  registerSize  returned element
- `memRdValid`  in  1  `memRdData` valid this cycle
- `regWrEn`  out  1  one-cycle register-file write pulse
- `regToWrite`  out  selectionBits  destination index, valid with `regWrEn`
- `regWriteData`  out  vectorSize×registerSize  packed vector, lane j in slice [j]
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse, coincident with `regWrEn`
- `laneMask`  in  vectorSize  per-lane enable (only with `VEC_LOAD_MASK_EN`)

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE: on `start`=1, latch `baseAddr`, `stride` and `destReg`. Clear the lane counter and the packing buffer, then go to REQ. `start` is ignored in every other state.
- REQ: assert `memRdEn` for exactly one cycle with `memAddr = base + lane*stride` (mod 2^addrWidth, wrap-around silent), then go to WAIT.
- WAIT: hold until `memRdValid`=1, then capture `memRdData` into buffer lane `lane`.
  - Last lane: go to WRITE.
  - Otherwise: increment `lane` and go to REQ.
- WRITE: `regWrEn`=1 and `done`=1 for one cycle, with `regToWrite` = latched `destReg`. Then return to IDLE.
- `memRdValid` is ignored outside WAIT.
- `regWriteData` is registered. It holds the last written vector until the next WRITE.
- Lane counter width is `$clog2(vectorSize)`, minimum 1. Address arithmetic truncates to addrWidth.
- Reset, including mid-operation:
  - State goes to IDLE; the lane counter and buffer clear.
  - `memRdEn`, `regWrEn`, `done`, `busy` = 0; `memAddr`, `regToWrite`, `regWriteData` = 0.
  - An aborted load never produces a write. A `memRdValid` arriving after the reset is ignored.

## Timing
- `start` is seen at edge 0. Each lane then costs 1 REQ cycle plus the memory latency L≥1 cycles in WAIT.
- With L=1, REQ cycles fall at 1, 3, 5, …, valid data at 2, 4, …, and WRITE at cycle 2·vectorSize+1. For vectorSize=4, `regWrEn` is high in cycle 9.
- A back-to-back `start` is accepted in the IDLE cycle right after WRITE, giving a minimum 1 dead cycle between loads.
- `busy` rises the cycle after `start` is accepted and falls the cycle after WRITE.

## Configuration
- `VEC_LOAD_MASK_EN` defined:
  - The `laneMask` port exists and is latched at start.
  - Lanes with mask bit 0 issue no memory request and are written as 0. The FSM skips directly to the next enabled lane's REQ.
  - An all-zero mask goes IDLE→WRITE: zero vector, `regWrEn` in cycle 1, no `memRdEn`.
- Not defined:
  - No `laneMask` port; all lanes are fetched.
  - Cycle timing as in the Timing section.

## Test plan
- Basic load, vectorSize=4, base=0x0010, stride=1, destReg=2, memory returns 0xA0+lane at L=1:
  - Addresses must be 0x10, 0x11, 0x12, 0x13.
  - `regWrEn` in cycle 9 with `regToWrite`=2 and data {0xA3,0xA2,0xA1,0xA0}, lane 0 in the LSB slice.
- Stride and wrap, base=0xFFFE, stride=3:
  - Addresses must be 0xFFFE, 0x0001, 0x0004, 0x0007.
- Variable latency (L=3 on lane 1, L=1 elsewhere), plus spurious `memRdValid` pulses in REQ and IDLE:
  - Only WAIT-cycle data is captured.
  - WRITE occurs in cycle 11.
- `start` pulsed while busy, then `reset` asserted during WAIT of lane 2:
  - The second `start` is ignored.
  - After reset, all outputs are 0 and no `regWrEn` ever fires for the aborted load.
  - A fresh load afterwards completes normally.
- With `VEC_LOAD_MASK_EN`, mask=4'b0101:
  - Only addresses for lanes 0 and 2 are requested.
  - `regWriteData` = {0, d2, 0, d0}.
  - mask=0 gives `regWrEn` in cycle 1 with an all-zero vector.
